// File: rtl/match_pkg.sv
// ---------------------------------------------------------------------------
// match_pkg
//   Shared definitions for the match_sequencer slice: default widths/depths,
//   the byte-offset type, the maximum pattern length and helpers that turn a
//   raw pattern_length into a clamped length and a one-hot hit-tap mask.
// ---------------------------------------------------------------------------
package match_pkg;

    localparam int DEFAULT_POS_WIDTH  = 16;
    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int PATTERN_MAX        = 8;

    typedef logic [DEFAULT_POS_WIDTH-1:0] pos_t;

    // Lengths above PATTERN_MAX behave as PATTERN_MAX; 0 stays 0 (disabled).
    function automatic logic [3:0] clamp_length(input logic [3:0] len);
        return (len > 4'(PATTERN_MAX)) ? 4'(PATTERN_MAX) : len;
    endfunction

    // One-hot mask selecting state bit L-1; all zero when detection is off.
    function automatic logic [PATTERN_MAX-1:0] length_mask(input logic [3:0] len);
        logic [3:0]             l;
        logic [PATTERN_MAX-1:0] m;
        l = clamp_length(len);
        m = '0;
        for (int i = 0; i < PATTERN_MAX; i++) begin
            if (l == 4'(i + 1)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/match_event_fifo.sv
// ---------------------------------------------------------------------------
// match_event_fifo
//   Synchronous FIFO holding hit offsets until the AXI-Stream consumer takes
//   them. A push into a full FIFO is accepted only when a pop happens in the
//   same cycle; otherwise it is ignored and the caller flags the drop.
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   clear        synchronous flush (pointers and count to zero)
//   push, push_data   write request and payload
//   pop          read request (ignored when empty)
//   pop_data     head entry (stale when empty)
//   full, empty  occupancy flags
// ---------------------------------------------------------------------------
module match_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == (AW + 1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/match_sequencer.sv
// ---------------------------------------------------------------------------
// match_sequencer
//   Shift-and (bitap) detector for patterns of up to 8 bytes. Each input beat
//   is a vector whose bit i says "this byte equals pattern byte i". When a
//   full occurrence completes, the 0-based stream offset of its last byte is
//   queued and presented on an AXI-Stream master.
//   Pipeline: input register -> state/hit register -> event FIFO.
// Ports
//   aclk, aresetn        clock, synchronous active-low reset
//   s_axis_tvalid/tdata  match vectors (always consumed, no tready)
//   pattern_length       1..8 active, 0 disables, 9..15 act as 8
//   clear                synchronous soft clear of everything below
//   m_axis_*             hit offsets, backpressured by m_axis_tready
//   overflow             sticky, set when a hit is dropped on a full FIFO
//   match_count          (MATCH_COUNT_EN only) saturating total hit count
// Configuration
//   MATCH_COUNT_EN  adds the match_count port and its counter.
// ---------------------------------------------------------------------------
module match_sequencer
    import match_pkg::*;
#(
    parameter int POS_WIDTH  = DEFAULT_POS_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 s_axis_tvalid,
    input  logic [7:0]           s_axis_tdata,
    input  logic [3:0]           pattern_length,
    input  logic                 clear,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [POS_WIDTH-1:0] m_axis_tdata,
    output logic                 overflow
`ifdef MATCH_COUNT_EN
    ,
    output logic [15:0]          match_count
`endif
);

    logic                 beat_valid_q, beat_valid_d;
    logic [7:0]           beat_data_q, beat_data_d;
    logic [3:0]           beat_len_q, beat_len_d;
    logic [7:0]           s_q, s_d;
    logic [POS_WIDTH-1:0] offset_q, offset_d;
    logic                 hit_q, hit_d;
    logic [POS_WIDTH-1:0] hit_pos_q, hit_pos_d;
    logic                 overflow_q, overflow_d;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    // The length travels with its beat so a change applies from the next beat.
    always_comb begin
        beat_valid_d = s_axis_tvalid & ~clear;
        beat_data_d  = s_axis_tdata;
        beat_len_d   = pattern_length;
    end

    // Bitap update: bit i of S means the last i+1 beats matched pattern[0..i].
    // Gaps (no valid beat) freeze S and the offset.
    always_comb begin
        s_d       = s_q;
        offset_d  = offset_q;
        hit_d     = 1'b0;
        hit_pos_d = hit_pos_q;
        if (clear) begin
            s_d       = '0;
            offset_d  = '0;
            hit_pos_d = '0;
        end else if (beat_valid_q) begin
            s_d       = ((s_q << 1) | 8'h01) & beat_data_q;
            hit_d     = |(s_d & length_mask(beat_len_q));
            hit_pos_d = offset_q;
            offset_d  = offset_q + POS_WIDTH'(1);
        end
    end

    assign pop           = m_axis_tvalid & m_axis_tready;
    assign m_axis_tvalid = ~fifo_empty;
    assign overflow      = overflow_q;

    // A hit is lost only when the FIFO is full and nothing leaves this cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (clear) begin
            overflow_d = 1'b0;
        end else if (hit_q && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            beat_valid_q <= 1'b0;
            beat_data_q  <= '0;
            beat_len_q   <= '0;
            s_q          <= '0;
            offset_q     <= '0;
            hit_q        <= 1'b0;
            hit_pos_q    <= '0;
            overflow_q   <= 1'b0;
        end else begin
            beat_valid_q <= beat_valid_d;
            beat_data_q  <= beat_data_d;
            beat_len_q   <= beat_len_d;
            s_q          <= s_d;
            offset_q     <= offset_d;
            hit_q        <= hit_d;
            hit_pos_q    <= hit_pos_d;
            overflow_q   <= overflow_d;
        end
    end

    match_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (POS_WIDTH)
    ) u_fifo (
        .clk       (aclk),
        .rst_n     (aresetn),
        .clear     (clear),
        .push      (hit_q),
        .push_data (hit_pos_q),
        .pop       (pop),
        .pop_data  (m_axis_tdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef MATCH_COUNT_EN
    logic [15:0] count_q, count_d;

    // Counts every detected hit, dropped or not, and sticks at all-ones.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (hit_q && count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign match_count = count_q;
`endif

endmodule

// File: tb/tb_match_sequencer.sv
// ---------------------------------------------------------------------------
// tb_match_sequencer
//   Self-checking bench for match_sequencer. A reference model keeps the
//   recent beat history and decides hits directly from the definition of an
//   occurrence; expected offsets go into a queue that a negedge monitor pops
//   whenever the DUT hands over an event.
// ---------------------------------------------------------------------------
module tb_match_sequencer;

    localparam int PW    = 16;
    localparam int DEPTH = 4;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          s_axis_tvalid;
    logic [7:0]    s_axis_tdata;
    logic [3:0]    pattern_length;
    logic          clear;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [PW-1:0] m_axis_tdata;
    logic          overflow;
`ifdef MATCH_COUNT_EN
    logic [15:0]   match_count;
`endif

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model state
    bit         st_valid;
    logic [7:0] st_data;
    logic [3:0] st_len;
    bit         hit_pend;
    int         hit_pos;
    logic [7:0] hist[$];
    int         offset;
    int         fcount;
    bit         m_ovf;
    int         m_count;
    int         exp_q[$];

    always #5 aclk = ~aclk;

    match_sequencer dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tdata   (s_axis_tdata),
        .pattern_length (pattern_length),
        .clear          (clear),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .overflow       (overflow)
`ifdef MATCH_COUNT_EN
        ,
        .match_count    (match_count)
`endif
    );

    // Compares one observed value against its expectation and logs failures.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle worth of inputs shortly after the rising edge.
    task automatic applyStimulus(input logic rstn, input logic v, input logic [7:0] d,
                                 input logic [3:0] l, input logic clr, input logic rdy);
        @(posedge aclk);
        #2;
        aresetn        = rstn;
        s_axis_tvalid  = v;
        s_axis_tdata   = d;
        pattern_length = l;
        clear          = clr;
        m_axis_tready  = rdy;
    endtask

    // Occurrence of length L ends at the newest beat when, for every j < L,
    // the beat j positions back matched pattern byte L-1-j.
    function automatic bit modelHit(input logic [3:0] len);
        int         l;
        logic [7:0] b;
        bit         h;
        l = (len > 4'd8) ? 8 : int'(len);
        if (l == 0 || hist.size() < l) return 1'b0;
        h = 1'b1;
        for (int j = 0; j < l; j++) begin
            b = hist[hist.size() - 1 - j];
            if (!b[l - 1 - j]) h = 1'b0;
        end
        return h;
    endfunction

    // Reference model, advanced once per rising edge.
    always @(posedge aclk) begin
        bit pop_m;
        if (!aresetn || clear) begin
            st_valid = 1'b0;
            hit_pend = 1'b0;
            hit_pos  = 0;
            hist.delete();
            offset   = 0;
            fcount   = 0;
            m_ovf    = 1'b0;
            m_count  = 0;
            exp_q.delete();
        end else begin
            pop_m = (fcount > 0) && m_axis_tready;
            if (hit_pend) begin
                if (m_count < 16'hFFFF) m_count++;
                if (fcount < DEPTH || pop_m) begin
                    exp_q.push_back(hit_pos);
                    fcount++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (pop_m) fcount--;
            hit_pend = 1'b0;
            if (st_valid) begin
                hist.push_back(st_data);
                if (hist.size() > 8) void'(hist.pop_front());
                hit_pend = modelHit(st_len);
                hit_pos  = offset;
                offset   = (offset + 1) & 16'hFFFF;
            end
            st_valid = s_axis_tvalid;
            st_data  = s_axis_tdata;
            st_len   = pattern_length;
        end
    end

    // Monitor: checks handshake state every cycle and pops on each transfer.
    always @(negedge aclk) begin
        int e;
        if (mon_en) begin
            checkOutput("tvalid", 32'(m_axis_tvalid), 32'(fcount > 0));
            checkOutput("overflow", 32'(overflow), 32'(m_ovf));
`ifdef MATCH_COUNT_EN
            checkOutput("match_count", 32'(match_count), 32'(m_count));
`endif
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL tdata: got %0h expected no event at %0t", m_axis_tdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("tdata", 32'(m_axis_tdata), 32'(e));
                end
            end
        end
    end

    initial begin
        aresetn        = 1'b0;
        s_axis_tvalid  = 1'b0;
        s_axis_tdata   = '0;
        pattern_length = '0;
        clear          = 1'b0;
        m_axis_tready  = 1'b1;
        repeat (3) applyStimulus(0, 0, 8'h00, 4'd0, 0, 1);
        applyStimulus(1, 0, 8'h00, 4'd3, 0, 1);
        @(negedge aclk);
        checkOutput("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("reset_tdata", 32'(m_axis_tdata), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        mon_en = 1'b1;

        // Pattern of length 3 in order, then idle to let the event out.
        applyStimulus(1, 1, 8'h01, 4'd3, 0, 1);
        applyStimulus(1, 1, 8'h02, 4'd3, 0, 1);
        applyStimulus(1, 1, 8'h04, 4'd3, 0, 1);
        repeat (4) applyStimulus(1, 0, 8'h00, 4'd3, 0, 1);

        // Overlapping "aa" hits.
        repeat (3) applyStimulus(1, 1, 8'h03, 4'd2, 0, 1);
        repeat (4) applyStimulus(1, 0, 8'h00, 4'd2, 0, 1);

        // Broken sequence gives nothing.
        applyStimulus(1, 1, 8'h01, 4'd3, 0, 1);
        applyStimulus(1, 1, 8'h02, 4'd3, 0, 1);
        applyStimulus(1, 1, 8'h00, 4'd3, 0, 1);
        applyStimulus(1, 1, 8'h04, 4'd3, 0, 1);
        repeat (4) applyStimulus(1, 0, 8'h00, 4'd3, 0, 1);

        // Overfill the FIFO with backpressure, then drain in order.
        applyStimulus(1, 0, 8'h00, 4'd1, 1, 0);
        repeat (6) applyStimulus(1, 1, 8'h01, 4'd1, 0, 0);
        repeat (3) applyStimulus(1, 0, 8'h00, 4'd1, 0, 0);
        @(negedge aclk);
        checkOutput("full_overflow", 32'(overflow), 32'd1);
        checkOutput("full_head", 32'(m_axis_tdata), 32'd0);
        repeat (6) applyStimulus(1, 0, 8'h00, 4'd1, 0, 1);

        // Fill exactly, then push and pop together on a full FIFO.
        applyStimulus(1, 0, 8'h00, 4'd1, 1, 0);
        repeat (4) applyStimulus(1, 1, 8'h01, 4'd1, 0, 0);
        applyStimulus(1, 1, 8'h01, 4'd1, 0, 0);
        applyStimulus(1, 0, 8'h00, 4'd1, 0, 0);
        applyStimulus(1, 0, 8'h00, 4'd1, 0, 1);
        repeat (2) applyStimulus(1, 0, 8'h00, 4'd1, 0, 0);
        @(negedge aclk);
        checkOutput("pushpop_overflow", 32'(overflow), 32'd0);
        checkOutput("pushpop_tvalid", 32'(m_axis_tvalid), 32'd1);

        // Clear wins over a coincident beat; offsets restart at zero.
        applyStimulus(1, 1, 8'h01, 4'd1, 1, 0);
        applyStimulus(1, 0, 8'h00, 4'd1, 0, 0);
        @(negedge aclk);
        checkOutput("clear_tvalid", 32'(m_axis_tvalid), 32'd0);
        applyStimulus(1, 1, 8'h01, 4'd1, 0, 0);
        repeat (3) applyStimulus(1, 0, 8'h00, 4'd1, 0, 0);
        @(negedge aclk);
        checkOutput("clear_offset0", 32'(m_axis_tdata), 32'd0);
        repeat (2) applyStimulus(1, 0, 8'h00, 4'd1, 0, 1);

        // Offset wrap: 65535 non-matching beats, then two hits.
        applyStimulus(1, 0, 8'h00, 4'd1, 1, 1);
        for (int i = 0; i < 65535; i++) applyStimulus(1, 1, 8'h00, 4'd1, 0, 1);
        applyStimulus(1, 1, 8'h01, 4'd1, 0, 0);
        repeat (3) applyStimulus(1, 0, 8'h00, 4'd1, 0, 0);
        @(negedge aclk);
        checkOutput("wrap_ffff", 32'(m_axis_tdata), 32'h0000FFFF);
        applyStimulus(1, 1, 8'h01, 4'd1, 0, 1);
        repeat (4) applyStimulus(1, 0, 8'h00, 4'd1, 0, 1);

        // Randomized traffic with occasional clears and one mid-stream reset.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus((i == 1500) ? 1'b0 : 1'b1,
                          1'($urandom_range(0, 3) != 0),
                          8'($urandom | $urandom),
                          4'($urandom_range(0, 10)),
                          1'($urandom_range(0, 99) == 0),
                          1'($urandom_range(0, 2) != 0));
        end

        repeat (10) applyStimulus(1, 0, 8'h00, 4'd1, 0, 1);
        @(negedge aclk);
        checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
